piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_bitcnt.sv | 20 ++
 rtl/piso_serializer.sv | 61 ++++++
 tb/tb_piso_serializer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and defaults for the PISO serializer (PARITY state only with PISO_PARITY_EN)
package piso_pkg;
  localparam int PISO_DEFAULT_WIDTH = 4;
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} piso_state_t;
`endif
endpackage

// File: rtl/piso_bitcnt.sv
// piso_bitcnt: counts data bits of a frame and flags the final one, wrapping to 0
module piso_bitcnt
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] r_cnt;
  assign last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (inc) r_cnt <= last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out with back-to-back loading
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done
);
  piso_state_t      r_state, w_state_n;
  logic [WIDTH-1:0] r_shreg;
  logic             w_last, w_final, w_load, w_shift, w_bit;
  assign w_shift    = r_state == SHIFT;
  assign w_bit      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_load     = load_valid & load_ready;
  assign load_ready = (r_state == IDLE) | w_final;
  assign dout_valid = r_state != IDLE;
  assign frame_done = w_final;
`ifdef PISO_PARITY_EN
  logic r_par;
  assign w_final = r_state == PARITY;
  assign dout    = w_shift ? w_bit : (w_final & r_par);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_par <= 1'b0;
    else if (w_load) r_par <= ^din;
`else
  assign w_final = w_shift & w_last;
  assign dout    = w_shift & w_bit;
`endif
  piso_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk  (clk),
    .reset(reset),
    .clear(w_load),
    .inc  (w_shift),
    .last (w_last)
  );
  always_comb begin
    w_state_n = r_state;
    if (w_load) w_state_n = SHIFT;
    else if (w_final) w_state_n = IDLE;
`ifdef PISO_PARITY_EN
    else if (w_shift && w_last) w_state_n = PARITY;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_n;
  // the outgoing bit always sits at the end selected by MSB_FIRST
  always_ff @(posedge clk or posedge reset)
    if (reset) r_shreg <= '0;
    else if (w_load) r_shreg <= din;
    else if (w_shift) r_shreg <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of LSB-first and MSB-first instances
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'd0;
  logic       load_valid = 1'b0;
  logic       l_ready, l_dout, l_valid, l_done;
  logic       m_ready, m_dout, m_valid, m_done;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(l_ready), .dout(l_dout), .dout_valid(l_valid), .frame_done(l_done)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(m_ready), .dout(m_dout), .dout_valid(m_valid), .frame_done(m_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".dout"}, l_dout, 0);
    chk({tag, ".valid"}, l_valid, 0);
    chk({tag, ".done"}, l_done, 0);
    chk({tag, ".ready"}, l_ready, 1);
  endtask

  logic [7:0] exp8;
  logic [3:0] exp4;

  initial begin
    #2;
    chk_idle("rst");
    chk("rst.m_ready", m_ready, 1);
    step();
    reset = 1'b0;
`ifdef PISO_PARITY_EN
    din = 4'b0111;
    load_valid = 1'b1;
    exp4 = 4'b0111;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) load_valid = 1'b0;
      chk($sformatf("par.dout%0d", i), l_dout, (i == 5) ? 1 : exp4[i-1]);
      chk($sformatf("par.valid%0d", i), l_valid, 1);
      chk($sformatf("par.done%0d", i), l_done, i == 5);
      chk($sformatf("par.ready%0d", i), l_ready, i == 5);
      chk($sformatf("par.mdout%0d", i), m_dout, (i == 5) ? 1 : exp4[4-i]);
    end
    step();
    chk_idle("par.end");
`else
    din = 4'b1011;
    load_valid = 1'b1;
    exp4 = 4'b1011;
    for (int i = 1; i <= 4; i++) begin
      step();
      load_valid = 1'b0;
      chk($sformatf("one.dout%0d", i), l_dout, exp4[i-1]);
      chk($sformatf("one.valid%0d", i), l_valid, 1);
      chk($sformatf("one.done%0d", i), l_done, i == 4);
      chk($sformatf("one.ready%0d", i), l_ready, i == 4);
      chk($sformatf("msb.dout%0d", i), m_dout, exp4[4-i]);
      chk($sformatf("msb.valid%0d", i), m_valid, 1);
      chk($sformatf("msb.done%0d", i), m_done, i == 4);
    end
    step();
    chk_idle("one.end");
    din = 4'b0001;
    load_valid = 1'b1;
    exp8 = 8'b1000_0001;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("b2b.dout%0d", i), l_dout, exp8[i-1]);
      chk($sformatf("b2b.valid%0d", i), l_valid, 1);
      chk($sformatf("b2b.ready%0d", i), l_ready, (i == 4) || (i == 8));
      if (i == 1) din = 4'b1000;
      if (i == 8) load_valid = 1'b0;
    end
    step();
    chk_idle("b2b.end");
    din = 4'b1011;
    load_valid = 1'b1;
    exp4 = 4'b1011;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("mid.dout%0d", i), l_dout, exp4[i-1]);
      chk($sformatf("mid.ready%0d", i), l_ready, i == 4);
      load_valid = (i != 2) && (i != 4);
      din = 4'(4'b0100 + i);
    end
    step();
    chk_idle("mid.end");
    din = 4'b1111;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("rst.bit1", l_dout, 1);
    step();
    chk("rst.bit2", l_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk_idle("async");
    step();
    reset = 1'b0;
    step();
    chk("abort.valid", l_valid, 0);
    chk("abort.ready", l_ready, 1);
    din = 4'b0101;
    load_valid = 1'b1;
    exp4 = 4'b0101;
    for (int i = 1; i <= 4; i++) begin
      step();
      load_valid = 1'b0;
      chk($sformatf("post.dout%0d", i), l_dout, exp4[i-1]);
      chk($sformatf("post.valid%0d", i), l_valid, 1);
    end
    step();
    chk_idle("post.end");
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
